// File: rtl/bure_mem_responder.sv
// Request/response memory responder: word-addressed SRAM with byte-enabled writes,
// fixed-latency in-order responses through a bounded response buffer.
module bure_mem_responder #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int DEPTH_WORDS     = 1024,
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_req,
   output logic                    o_gnt,
   input  logic                    i_we,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   input  logic [DATA_WIDTH/8-1:0] i_be,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   output logic                    o_rvalid,
   input  logic                    i_rready,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic                    o_rerr
);
   localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int NBE  = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] w_word;
   logic [IDXW-1:0]       w_idx;
   logic                  w_err, w_acc, w_ret, w_push;
   logic [LATENCY-1:0]    w_pv, w_pe;
   logic [DATA_WIDTH-1:0] w_pd [LATENCY];

   logic [CW-1:0]         r_cnt, r_bcnt;
   logic [PW-1:0]         r_wp, r_rp;
   logic [DATA_WIDTH-1:0] r_fd [MAX_OUTSTANDING];
   logic                  r_fe [MAX_OUTSTANDING];

   assign w_word = i_addr >> 2;
   assign w_idx  = w_word[IDXW-1:0];
   assign w_err  = (i_addr[1:0] != 2'b00) || (w_word >= ADDR_WIDTH'(DEPTH_WORDS));
   assign o_gnt  = (r_cnt < CW'(MAX_OUTSTANDING));
   assign w_acc  = i_req & o_gnt;
   assign w_ret  = o_rvalid & i_rready;

   always_ff @(posedge i_clk) begin
      if (w_acc && i_we && !w_err) begin
         for (int k = 0; k < NBE; k++)
            if (i_be[k]) r_mem[w_idx][8*k +: 8] <= i_wdata[8*k +: 8];
      end
   end

   // Stage 0 is the accepting cycle itself, so the buffer push lands LATENCY edges after accept.
   assign w_pv[0] = w_acc;
   assign w_pe[0] = w_err;
   assign w_pd[0] = (i_we || w_err) ? '0 : r_mem[w_idx];

   for (genvar s = 1; s < LATENCY; s++) begin : g_stage
      logic                  r_v, r_e;
      logic [DATA_WIDTH-1:0] r_d;
      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            r_v <= 1'b0;
            r_e <= 1'b0;
            r_d <= '0;
         end else begin
            r_v <= w_pv[s-1];
            r_e <= w_pe[s-1];
            r_d <= w_pd[s-1];
         end
      end
      assign w_pv[s] = r_v;
      assign w_pe[s] = r_e;
      assign w_pd[s] = r_d;
   end

   assign w_push = w_pv[LATENCY-1];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt  <= '0;
         r_bcnt <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_fd[i] <= '0;
            r_fe[i] <= 1'b0;
         end
      end else begin
         case ({w_acc, w_ret})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
         case ({w_push, w_ret})
            2'b10:   r_bcnt <= r_bcnt + CW'(1);
            2'b01:   r_bcnt <= r_bcnt - CW'(1);
            default: r_bcnt <= r_bcnt;
         endcase
         if (w_push) begin
            r_fd[r_wp] <= w_pd[LATENCY-1];
            r_fe[r_wp] <= w_pe[LATENCY-1];
            r_wp       <= (r_wp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_wp + PW'(1);
         end
         if (w_ret)
            r_rp <= (r_rp == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_rp + PW'(1);
      end
   end

   assign o_rvalid = (r_bcnt != '0);
   assign o_rdata  = o_rvalid ? r_fd[r_rp] : '0;
   assign o_rerr   = o_rvalid ? r_fe[r_rp] : 1'b0;

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
      !(w_push && !w_ret && (r_bcnt == CW'(MAX_OUTSTANDING))));

endmodule

// File: tb/tb_bure_mem_responder.sv
// Scoreboard bench for bure_mem_responder: two instances (L=1/M=2 and L=3/M=4)
// sharing clock and reset; expectations are queued at accept and checked at retire.
module tb_bure_mem_responder;
   typedef struct {
      logic [31:0] d;
      logic        e;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req    [2];
   logic        gnt    [2];
   logic        we     [2];
   logic [31:0] addr   [2];
   logic [3:0]  be     [2];
   logic [31:0] wdata  [2];
   logic        rvalid [2];
   logic        rready [2];
   logic [31:0] rdata  [2];
   logic        rerr   [2];

   exp_t        q0[$], q1[$];
   int          rc1[$];
   logic [31:0] mdl0[int], mdl1[int];
   int          n_chk = 0, n_err = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bure_mem_responder #(.LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req[0]), .o_gnt(gnt[0]), .i_we(we[0]),
      .i_addr(addr[0]), .i_be(be[0]), .i_wdata(wdata[0]), .o_rvalid(rvalid[0]),
      .i_rready(rready[0]), .o_rdata(rdata[0]), .o_rerr(rerr[0]));

   bure_mem_responder #(.LATENCY(3), .MAX_OUTSTANDING(4)) u1 (
      .i_clk(clk), .i_rstn(rstn), .i_req(req[1]), .o_gnt(gnt[1]), .i_we(we[1]),
      .i_addr(addr[1]), .i_be(be[1]), .i_wdata(wdata[1]), .o_rvalid(rvalid[1]),
      .i_rready(rready[1]), .o_rdata(rdata[1]), .o_rerr(rerr[1]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Reference model: computes the response and updates the shadow array.
   task automatic model(input int u, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd, output exp_t e);
      logic [31:0] cur;
      int          idx;
      idx   = int'(a >> 2);
      e.e   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
      e.d   = '0;
      e.acc = cyc + 1;
      if (!e.e) begin
         if (u == 0) cur = mdl0.exists(idx) ? mdl0[idx] : '0;
         else        cur = mdl1.exists(idx) ? mdl1[idx] : '0;
         if (w) begin
            for (int k = 0; k < 4; k++) if (b[k]) cur[8*k +: 8] = wd[8*k +: 8];
            if (u == 0) mdl0[idx] = cur;
            else        mdl1[idx] = cur;
         end else begin
            e.d = cur;
         end
      end
   endtask

   task automatic push_exp(input int u, input exp_t e);
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   // Call at posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input int u, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] wd);
      int   n;
      exp_t e;
      n = 0;
      req[u] = 1'b1; we[u] = w; addr[u] = a; be[u] = b; wdata[u] = wd;
      @(negedge clk);
      while (!gnt[u] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!gnt[u]) chk("gnt_timeout", {31'b0, gnt[u]}, 32'd1);
      else begin
         model(u, w, a, b, wd, e);
         push_exp(u, e);
      end
      @(posedge clk); #1;
      req[u] = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drain(input int u);
      int n;
      n = 0;
      while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", (u == 0) ? q0.size() : q1.size(), 0);
      step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rstn && rvalid[0] && rready[0]) begin
         if (q0.size() == 0) chk("unexpected_rsp0", 32'd1, 32'd0);
         else begin
            e = q0.pop_front();
            chk("rdata0", rdata[0], e.d);
            chk("rerr0", {31'b0, rerr[0]}, {31'b0, e.e});
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rstn && rvalid[1] && rready[1]) begin
         rc1.push_back(cyc);
         if (q1.size() == 0) chk("unexpected_rsp1", 32'd1, 32'd0);
         else begin
            e = q1.pop_front();
            chk("rdata1", rdata[1], e.d);
            chk("rerr1", {31'b0, rerr[1]}, {31'b0, e.e});
         end
      end
   end

   initial begin
      int          acc, a0;
      logic [31:0] hold_addr [3];
      exp_t        e;
      for (int u = 0; u < 2; u++) begin
         req[u] = 0; we[u] = 0; addr[u] = 0; be[u] = 0; wdata[u] = 0; rready[u] = 1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
      chk("rst_rdata", rdata[0], 32'd0);
      chk("rst_rerr", {31'b0, rerr[0]}, 32'd0);
      rstn = 1'b1;
      step();
      chk("rst_gnt", {31'b0, gnt[0]}, 32'd1);

      // Basic write then read with LATENCY=1 timing
      issue(0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      chk("lat1_wack", {31'b0, rvalid[0]}, 32'd1);
      step();
      issue(0, 0, 32'h10, 4'h0, 32'h0);
      @(negedge clk);
      chk("lat1_read", {31'b0, rvalid[0]}, 32'd1);
      step();

      // Partial byte-enable write
      issue(0, 1, 32'h20, 4'hF, 32'h11223344);
      issue(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD);
      issue(0, 0, 32'h20, 4'h0, 32'h0);
      issue(0, 1, 32'h40, 4'hF, 32'h5A5A0F0F);
      issue(0, 1, 32'h44, 4'h0, 32'hFFFFFFFF);
      issue(0, 0, 32'h44, 4'h0, 32'h0);
      drain(0);

      // Error decode
      issue(0, 1, 32'h0, 4'hF, 32'hCAFEF00D);
      issue(0, 0, 32'h3, 4'h0, 32'h0);
      issue(0, 0, 32'd4096, 4'h0, 32'h0);
      issue(0, 1, 32'd4096, 4'hF, 32'h12345678);
      issue(0, 0, 32'h0, 4'h0, 32'h0);
      drain(0);

      // Back-pressure: req held high, rready low
      hold_addr[0] = 32'h10; hold_addr[1] = 32'h20; hold_addr[2] = 32'h40;
      rready[0] = 0;
      acc = 0;
      req[0] = 1; we[0] = 0; be[0] = 0; addr[0] = hold_addr[0];
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (acc == 2) chk("gnt_hold", {31'b0, gnt[0]}, 32'd0);
         if (gnt[0]) begin
            model(0, 0, addr[0], 4'h0, 32'h0, e);
            push_exp(0, e);
            acc++;
            @(posedge clk); #1;
            addr[0] = hold_addr[acc % 3];
         end else begin
            step();
         end
      end
      chk("hold_accepts", acc, 2);
      rready[0] = 1;
      step();
      rready[0] = 0;
      @(negedge clk);
      chk("gnt_rise", {31'b0, gnt[0]}, 32'd1);
      model(0, 0, addr[0], 4'h0, 32'h0, e);
      push_exp(0, e);
      step();
      req[0] = 0;
      rready[0] = 1;
      drain(0);

      // LATENCY=3 streaming on the second instance
      issue(1, 1, 32'h0, 4'hF, 32'h01010101);
      issue(1, 1, 32'h4, 4'hF, 32'h02020202);
      issue(1, 1, 32'h8, 4'hF, 32'h03030303);
      issue(1, 1, 32'hC, 4'hF, 32'h04040404);
      drain(1);
      rc1.delete();
      a0 = cyc + 1;
      issue(1, 0, 32'h0, 4'h0, 32'h0);
      issue(1, 0, 32'h4, 4'h0, 32'h0);
      issue(1, 0, 32'h8, 4'h0, 32'h0);
      issue(1, 0, 32'hC, 4'h0, 32'h0);
      drain(1);
      chk("l3_count", rc1.size(), 4);
      for (int i = 0; i < 4 && i < rc1.size(); i++)
         chk("l3_cycle", rc1[i], a0 + 2 + i);

      // Reset with responses pending
      rready[0] = 0;
      issue(0, 0, 32'h10, 4'h0, 32'h0);
      issue(0, 0, 32'h20, 4'h0, 32'h0);
      @(negedge clk);
      chk("pend_rvalid", {31'b0, rvalid[0]}, 32'd1);
      chk("pend_gnt", {31'b0, gnt[0]}, 32'd0);
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
      q0.delete();
      step();
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_gnt", {31'b0, gnt[0]}, 32'd1);
      chk("post_rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
      rready[0] = 1;
      step();
      issue(0, 0, 32'h20, 4'h0, 32'h0);
      issue(0, 0, 32'h40, 4'h0, 32'h0);
      drain(0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
